// File: rtl/compare_datapath_if.sv
// Operand bus, load strobes and status flags between the compare/classify controller and its datapath.
// The controller uses master; the datapath uses slave.
interface compare_datapath_if #(
    parameter int WIDTH = 32
);
    logic             ldM;
    logic             ldQ;
    logic [WIDTH-1:0] data_in;

    logic             eqz1;
    logic             neqz1;
    logic             eqz2;
    logic             neqz2;
    logic             yes1;
    logic             no1;
    logic             yes2;
    logic             no2;
    logic             flags_valid;

    modport master (
        output ldM, ldQ, data_in,
        input  eqz1, neqz1, eqz2, neqz2, yes1, no1, yes2, no2, flags_valid
    );

    modport slave (
        input  ldM, ldQ, data_in,
        output eqz1, neqz1, eqz2, neqz2, yes1, no1, yes2, no2, flags_valid
    );
endinterface

// File: rtl/compare_datapath.sv
// Operand registers M/Q plus registered compare flags for the compare/classify controller.
// Latency: a load at edge k shows in the flags at edge k+1. There is no backpressure: loads are accepted every cycle.
// The optional saturating load counter (load_cnt port) is present only when DP_LOAD_CNT_EN is defined.
module compare_datapath #(
    parameter int WIDTH = 32
`ifdef DP_LOAD_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    compare_datapath_if.slave    dp
`ifdef DP_LOAD_CNT_EN
    ,
    output logic [CNT_W-1:0]     load_cnt
`endif
);

    typedef struct packed {
        logic eqz1;
        logic neqz1;
        logic eqz2;
        logic neqz2;
        logic yes1;
        logic no1;
        logic yes2;
        logic no2;
    } flags_t;

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic             m_seen;
    logic             q_seen;
    logic             valid_q;
    flags_t           flags_q;

    // Operand registers and first-load tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            q_q    <= '0;
            m_seen <= 1'b0;
            q_seen <= 1'b0;
        end else begin
            if (dp.ldM) begin
                m_q    <= dp.data_in;
                m_seen <= 1'b1;
            end
            if (dp.ldQ) begin
                q_q    <= dp.data_in;
                q_seen <= 1'b1;
            end
        end
    end

    // Compare logic works on the registered operands only.
    // The subtract is one bit wider than the operands, so M = all-ones with Q = 0 cannot overflow.
    logic             m_zero;
    logic             q_zero;
    logic             m_gt_q;
    logic [WIDTH:0]   diff;
    logic             diff_ge_q;
    logic             valid_nxt;
    flags_t           flags_nxt;

    always_comb begin
        m_zero    = (m_q == '0);
        q_zero    = (q_q == '0);
        m_gt_q    = (m_q > q_q);
        diff      = {1'b0, m_q} - {1'b0, q_q};
        diff_ge_q = (diff >= {1'b0, q_q});
        valid_nxt = m_seen & q_seen;

        flags_nxt = '0;
        if (valid_nxt) begin
            flags_nxt.eqz1  = m_zero;
            flags_nxt.neqz1 = ~m_zero;
            flags_nxt.eqz2  = q_zero;
            flags_nxt.neqz2 = ~q_zero;
            flags_nxt.yes1  = m_gt_q;
            flags_nxt.no1   = ~m_gt_q;
            // (M-Q)>=Q only means something when M>Q; otherwise report the "less" half
            flags_nxt.yes2  = m_gt_q & diff_ge_q;
            flags_nxt.no2   = ~(m_gt_q & diff_ge_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign dp.eqz1        = flags_q.eqz1;
    assign dp.neqz1       = flags_q.neqz1;
    assign dp.eqz2        = flags_q.eqz2;
    assign dp.neqz2       = flags_q.neqz2;
    assign dp.yes1        = flags_q.yes1;
    assign dp.no1         = flags_q.no1;
    assign dp.yes2        = flags_q.yes2;
    assign dp.no2         = flags_q.no2;
    assign dp.flags_valid = valid_q;

`ifdef DP_LOAD_CNT_EN
    // A cycle with both strobes set counts as one load. The counter saturates at all-ones and does not wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
        end else if ((dp.ldM | dp.ldQ) && (load_cnt != {CNT_W{1'b1}})) begin
            load_cnt <= load_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_compare_datapath.sv
// Directed, table-driven bench for compare_datapath: flag encodings, load latency, reset and the optional load counter.
module tb_compare_datapath;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    compare_datapath_if #(.WIDTH(32)) dp ();

`ifdef DP_LOAD_CNT_EN
    logic [7:0] load_cnt;
    compare_datapath #(.WIDTH(32), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dp       (dp),
        .load_cnt (load_cnt)
    );
`else
    compare_datapath #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dp)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {eqz1,neqz1,eqz2,neqz2,yes1,no1,yes2,no2}
    function automatic logic [7:0] get_flags();
        return {dp.eqz1, dp.neqz1, dp.eqz2, dp.neqz2, dp.yes1, dp.no1, dp.yes2, dp.no2};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call this at #1 after a rising edge. It returns one edge after the Q load, when the flags already reflect M and Q.
    task automatic load_mq(input logic [31:0] m, input logic [31:0] q);
        dp.ldM = 1'b1; dp.ldQ = 1'b0; dp.data_in = m;
        tick();
        dp.ldM = 1'b0; dp.ldQ = 1'b1; dp.data_in = q;
        tick();
        dp.ldQ = 1'b0;
        tick();
    endtask

    typedef struct {
        string       name;
        logic [31:0] m;
        logic [31:0] q;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{"m0_q5",        32'd0,          32'd5,          8'b10_01_01_01};
        vecs[1]  = '{"m20_q5",       32'd20,         32'd5,          8'b01_01_10_10};
        vecs[2]  = '{"m7_q5",        32'd7,          32'd5,          8'b01_01_10_01};
        vecs[3]  = '{"m3_q5",        32'd3,          32'd5,          8'b01_01_01_01};
        vecs[4]  = '{"m0_q0",        32'd0,          32'd0,          8'b10_10_01_01};
        vecs[5]  = '{"mmax_q0",      32'hFFFF_FFFF,  32'd0,          8'b01_10_10_10};
        vecs[6]  = '{"m10_q5_eq",    32'd10,         32'd5,          8'b01_01_10_10};
        vecs[7]  = '{"m9_q5",        32'd9,          32'd5,          8'b01_01_10_01};
        vecs[8]  = '{"m5_q5",        32'd5,          32'd5,          8'b01_01_01_01};
        vecs[9]  = '{"m1_q0",        32'd1,          32'd0,          8'b01_10_10_10};
        vecs[10] = '{"mmax_qmaxm1",  32'hFFFF_FFFF,  32'hFFFF_FFFE,  8'b01_01_10_01};
        vecs[11] = '{"mmax_qhalf",   32'hFFFF_FFFF,  32'h8000_0000,  8'b01_01_10_01};
        vecs[12] = '{"big_ge",       32'hFFFF_FFFE,  32'h7FFF_FFFF,  8'b01_01_10_10};

        rst_n = 1'b0; dp.ldM = 1'b0; dp.ldQ = 1'b0; dp.data_in = '0;
        repeat (2) tick();
        check("reset_flags", 32'(get_flags()), 32'h0);
        check("reset_valid", 32'(dp.flags_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // M=0 is loaded first and Q=5 one cycle later. flags_valid must rise only on the edge after the Q load.
        dp.ldM = 1'b1; dp.data_in = 32'd0;
        tick();
        check("seq2_valid_after_m", 32'(dp.flags_valid), 32'h0);
        dp.ldM = 1'b0; dp.ldQ = 1'b1; dp.data_in = 32'd5;
        tick();
        check("seq2_valid_at_q_edge", 32'(dp.flags_valid), 32'h0);
        check("seq2_flags_at_q_edge", 32'(get_flags()), 32'h0);
        dp.ldQ = 1'b0;
        tick();
        check("seq2_valid", 32'(dp.flags_valid), 32'h1);
        check("seq2_flags", 32'(get_flags()), 32'(8'b10_01_01_01));

        foreach (vecs[i]) begin
            load_mq(vecs[i].m, vecs[i].q);
            check({vecs[i].name, "_flags"}, 32'(get_flags()), 32'(vecs[i].exp));
            check({vecs[i].name, "_valid"}, 32'(dp.flags_valid), 32'h1);
        end

        // Reload M only (7 becomes 3). The flags change one edge after the load, not on the load edge.
        load_mq(32'd7, 32'd5);
        dp.ldM = 1'b1; dp.data_in = 32'd3;
        tick();
        dp.ldM = 1'b0;
        check("seq4_old_flags", 32'(get_flags()), 32'(8'b01_01_10_01));
        tick();
        check("seq4_new_flags", 32'(get_flags()), 32'(8'b01_01_01_01));

        // Both strobes high load the same value into M and Q. Then Q alone is reloaded with 0.
        dp.ldM = 1'b1; dp.ldQ = 1'b1; dp.data_in = 32'hFFFF_FFFF;
        tick();
        dp.ldM = 1'b0; dp.ldQ = 1'b0;
        tick();
        check("seq5_equal", 32'(get_flags()), 32'(8'b01_01_01_01));
        dp.ldQ = 1'b1; dp.data_in = 32'd0;
        tick();
        dp.ldQ = 1'b0;
        tick();
        check("seq5_q0", 32'(get_flags()), 32'(8'b01_10_10_10));

        // Assert reset asynchronously mid-cycle. The flags clear at once and stay clear until both operands are reloaded.
        load_mq(32'd9, 32'd4);
        check("seq1_before", 32'(get_flags()), 32'(8'b01_01_10_10));
        #2 rst_n = 1'b0;
        #1;
        check("seq1_async_flags", 32'(get_flags()), 32'h0);
        check("seq1_async_valid", 32'(dp.flags_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("seq1_idle_valid", 32'(dp.flags_valid), 32'h0);
        dp.ldM = 1'b1; dp.data_in = 32'd9;
        tick();
        dp.ldM = 1'b0;
        repeat (3) tick();
        check("seq1_m_only_valid", 32'(dp.flags_valid), 32'h0);
        check("seq1_m_only_flags", 32'(get_flags()), 32'h0);
        dp.ldQ = 1'b1; dp.data_in = 32'd4;
        tick();
        dp.ldQ = 1'b0;
        check("seq1_q_edge_valid", 32'(dp.flags_valid), 32'h0);
        tick();
        check("seq1_reload_valid", 32'(dp.flags_valid), 32'h1);
        check("seq1_reload_flags", 32'(get_flags()), 32'(8'b01_01_10_10));

`ifdef DP_LOAD_CNT_EN
        rst_n = 1'b0;
        tick();
        check("cnt_reset", 32'(load_cnt), 32'd0);
        rst_n = 1'b1;
        dp.ldM = 1'b1; dp.ldQ = 1'b1; dp.data_in = 32'd1;
        repeat (3) tick();
        dp.ldQ = 1'b0;
        check("cnt_dual_once", 32'(load_cnt), 32'd3);
        repeat (300) tick();
        check("cnt_saturate", 32'(load_cnt), 32'd255);
        dp.ldM = 1'b1; dp.ldQ = 1'b1;
        tick();
        dp.ldM = 1'b0; dp.ldQ = 1'b0;
        check("cnt_hold_max", 32'(load_cnt), 32'd255);
        rst_n = 1'b0;
        #1;
        check("cnt_reset_again", 32'(load_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
